// File: rtl/core_pkg.sv
// Shared core types: memory access size codes and LSU FSM states.
package core_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  function automatic logic size_legal(input logic [2:0] s);
    return (s == MEM_B)  || (s == MEM_H) ||
           (s == MEM_W)  || (s == MEM_BU) ||
           (s == MEM_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with
// sign/zero extension for loads. Purely combinational.
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_st_wdata,
  output logic [3:0]  o_st_wstrb,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;

  assign w_shift = i_ld_rdata >> {i_ld_off, 3'b000};

  // Store sizes only use the low two funct3 bits.
  always_comb begin
    o_st_wdata = '0;
    o_st_wstrb = '0;
    case (i_st_size)
      2'b00: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_wstrb = 4'b0001 << i_st_off;
      end
      2'b01: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_wstrb = 4'b0011 << i_st_off;
      end
      2'b10: begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      MEM_B:
        o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      MEM_BU:
        o_ld_data = {24'h0, w_shift[7:0]};
      MEM_H:
        o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      MEM_HU:
        o_ld_data = {16'h0, w_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: single-outstanding valid/ready
// data bus master with pipeline stall and response watchdog.
module lsu
  import core_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_readM,
  input  logic              mem_writeM,
  input  logic [2:0]        mem_sizeM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [31:0]       write_dataM,
  output logic [31:0]       read_dataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              bus_errM,
  output logic              dbus_valid,
  input  logic              dbus_ready,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic              dbus_rvalid,
  input  logic [31:0]       dbus_rdata
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [3:0]        r_wstrb;
  logic [2:0]        r_size;
  logic [1:0]        r_off;

  logic              w_access;
  logic              w_half;
  logic              w_illegal;
  logic              w_idle;
  logic              w_start;
  logic              w_tmo;
  logic [CW-1:0]     w_cnt_nxt;
  logic [31:0]       w_st_wdata;
  logic [3:0]        w_st_wstrb;
  logic [31:0]       w_ld_data;

  assign w_access = mem_readM | mem_writeM;
  assign w_half   = (mem_sizeM == MEM_H) |
                    (mem_sizeM == MEM_HU);
  assign w_illegal =
    (mem_readM & mem_writeM) |
    ~size_legal(mem_sizeM) |
    (w_half & addrM[0]) |
    ((mem_sizeM == MEM_W) & (addrM[1:0] != 2'b00));

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle & w_access & ~w_illegal;

  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_tmo = (TIMEOUT != 0) &&
                 (w_cnt_nxt == CW'(TIMEOUT));

  lsu_align u_align (
    .i_st_size  (mem_sizeM[1:0]),
    .i_st_off   (addrM[1:0]),
    .i_st_data  (write_dataM),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_rdata (dbus_rdata),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb),
    .o_ld_data  (w_ld_data)
  );

  // Stall is combinational in IDLE so the first cycle freezes.
  assign stallM = w_start |
                  (r_state == REQ) |
                  (r_state == RESP);
  assign misalignM  = w_idle & w_access & w_illegal & ~rst;
  assign bus_errM   = r_err;
  assign read_dataM = r_rdata;
  assign dbus_valid = (r_state == REQ);
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_wdata = r_wdata;
  assign dbus_wstrb = r_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wstrb <= '0;
      r_size  <= '0;
      r_off   <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_we    <= mem_writeM;
            r_addr  <= {addrM[ADDR_W-1:2], 2'b00};
            r_wdata <= mem_writeM ? w_st_wdata : '0;
            r_wstrb <= mem_writeM ? w_st_wstrb : '0;
            r_size  <= mem_sizeM;
            r_off   <= addrM[1:0];
          end
        end
        REQ: begin
          if (dbus_ready) begin
            r_state <= RESP;
            r_cnt   <= '0;
          end
        end
        RESP: begin
          // A response arriving with the timeout still wins.
          if (dbus_rvalid) begin
            if (!r_we) r_rdata <= w_ld_data;
            r_state <= DONE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed accesses, a reactive bus
// responder and a monitor comparing bus requests and completions.
module tb_lsu;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_readM, mem_writeM;
  logic [2:0]  mem_sizeM;
  logic [31:0] addrM, write_dataM;
  logic [31:0] read_dataM;
  logic        stallM, misalignM, bus_errM;
  logic        dbus_valid, dbus_ready, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  int          checks = 0;
  int          errors = 0;
  int          ready_dly = 0;
  int          rvalid_dly = 0;
  logic [31:0] bus_rdata = '0;
  int          q_mis = 0;
  req_t        q_req[$];
  done_t       q_done[$];

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_readM   (mem_readM),
    .mem_writeM  (mem_writeM),
    .mem_sizeM   (mem_sizeM),
    .addrM       (addrM),
    .write_dataM (write_dataM),
    .read_dataM  (read_dataM),
    .stallM      (stallM),
    .misalignM   (misalignM),
    .bus_errM    (bus_errM),
    .dbus_valid  (dbus_valid),
    .dbus_ready  (dbus_ready),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_wdata  (dbus_wdata),
    .dbus_wstrb  (dbus_wstrb),
    .dbus_rvalid (dbus_rvalid),
    .dbus_rdata  (dbus_rdata)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic exp_req(input logic we,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] s);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.strb = s;
    q_req.push_back(r);
  endtask

  task automatic exp_done(input logic [31:0] rd,
                          input logic err);
    done_t d;
    d.rd = rd; d.err = err;
    q_done.push_back(d);
  endtask

  // Called at posedge+1; holds the access until the cycle
  // in which stallM is low, then drops it after that edge.
  task automatic run(input logic rd, input logic wr,
                     input logic [2:0] sz,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rdat,
                     input int rdy, input int rvd,
                     input int exp_stall);
    int n;
    ready_dly = rdy; rvalid_dly = rvd; bus_rdata = rdat;
    mem_readM = rd; mem_writeM = wr; mem_sizeM = sz;
    addrM = a; write_dataM = wd;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!stallM) break;
      n++;
      if (n > 60) break;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    mem_readM = 1'b0; mem_writeM = 1'b0;
  endtask

  // Bus slave: ready after ready_dly REQ cycles, rvalid after
  // rvalid_dly RESP cycles (negative means never).
  initial begin
    int wc, rc;
    bit pend;
    wc = 0; rc = 0; pend = 0;
    dbus_ready = 0; dbus_rvalid = 0; dbus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dbus_ready = 0; dbus_rvalid = 0;
      dbus_rdata = bus_rdata;
      if (rst || !stallM) pend = 0;
      if (rst) wc = 0;
      else if (dbus_valid) begin
        dbus_ready = (wc >= ready_dly);
        wc++;
        if (dbus_ready) begin
          pend = 1; wc = 0; rc = 0;
        end
      end else if (pend) begin
        if (rvalid_dly >= 0 && rc >= rvalid_dly) begin
          dbus_rvalid = 1; pend = 0;
        end
        rc++;
      end else wc = 0;
    end
  end

  initial begin
    req_t  r;
    done_t d;
    bit    busy;
    busy = 0;
    forever begin
      @(negedge clk);
      if (rst) busy = 0;
      else begin
        if (dbus_valid) begin
          chk("req_expected", 32'(q_req.size() != 0), 1);
          if (q_req.size() != 0) begin
            r = q_req[0];
            chk("req_we", 32'(dbus_we), 32'(r.we));
            chk("req_addr", dbus_addr, r.addr);
            chk("req_wdata", dbus_wdata, r.wdata);
            chk("req_wstrb", 32'(dbus_wstrb), 32'(r.strb));
            if (dbus_ready) begin
              r = q_req.pop_front();
              busy = 1;
            end
          end
        end
        if (busy && !stallM) begin
          busy = 0;
          chk("done_expected",
              32'(q_done.size() != 0), 1);
          if (q_done.size() != 0) begin
            d = q_done.pop_front();
            chk("read_data", read_dataM, d.rd);
            chk("bus_err", 32'(bus_errM), 32'(d.err));
          end
        end else if (bus_errM) begin
          chk("spurious_bus_err", 32'(bus_errM), 0);
        end
        if (misalignM) begin
          chk("misalign_expected", 32'(q_mis > 0), 1);
          chk("misalign_no_valid", 32'(dbus_valid), 0);
          if (q_mis > 0) q_mis--;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=done");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    mem_readM = 0; mem_writeM = 0; mem_sizeM = '0;
    addrM = '0; write_dataM = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", read_dataM, 0);
    chk("rst_valid", 32'(dbus_valid), 0);
    chk("rst_we", 32'(dbus_we), 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_wstrb", 32'(dbus_wstrb), 0);
    chk("rst_misalign", 32'(misalignM), 0);
    chk("rst_bus_err", 32'(bus_errM), 0);
    chk("rst_stall", 32'(stallM), 0);
    rst = 0;
    @(posedge clk); #1;

    exp_req(1, 32'h100, 32'hDEADBEEF, 4'b1111);
    exp_done(32'h0, 0);
    run(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 3);

    exp_req(1, 32'h100, 32'hA5A5A5A5, 4'b1000);
    exp_done(32'h0, 0);
    run(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 3);

    exp_req(1, 32'h200, 32'hBEEFBEEF, 4'b1100);
    exp_done(32'h0, 0);
    run(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 0, 3);

    exp_req(0, 32'h100, 32'h0, 4'b0000);
    exp_done(32'hFFFFFFF0, 0);
    run(1, 0, 3'b000, 32'h102, 0, 32'h12F03456, 0, 0, 3);

    exp_req(0, 32'h100, 32'h0, 4'b0000);
    exp_done(32'h000000F0, 0);
    run(1, 0, 3'b100, 32'h102, 0, 32'h12F03456, 0, 0, 3);

    exp_req(0, 32'h100, 32'h0, 4'b0000);
    exp_done(32'h000012F0, 0);
    run(1, 0, 3'b101, 32'h102, 0, 32'h12F03456, 0, 0, 3);

    exp_req(0, 32'h100, 32'h0, 4'b0000);
    exp_done(32'hFFFF8456, 0);
    run(1, 0, 3'b001, 32'h100, 0, 32'h12F08456, 0, 0, 3);

    exp_req(0, 32'h104, 32'h0, 4'b0000);
    exp_done(32'h12F03456, 0);
    run(1, 0, 3'b010, 32'h104, 0, 32'h12F03456, 0, 0, 3);

    exp_req(1, 32'h108, 32'h11223344, 4'b1111);
    exp_done(32'h12F03456, 0);
    run(0, 1, 3'b010, 32'h108, 32'h11223344, 0, 0, 0, 3);

    q_mis++;
    run(1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 0);
    q_mis++;
    run(1, 1, 3'b010, 32'h100, 0, 0, 0, 0, 0);
    q_mis++;
    run(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0);
    q_mis++;
    run(1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0);
    q_mis++;
    run(0, 1, 3'b010, 32'h102, 32'h1, 0, 0, 0, 0);

    exp_req(0, 32'h300, 32'h0, 4'b0000);
    exp_done(32'hCAFEF00D, 0);
    run(1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 5, 0, 8);

    exp_req(0, 32'h400, 32'h0, 4'b0000);
    exp_done(32'h0, 1);
    run(1, 0, 3'b010, 32'h400, 0, 32'h77777777, 0, -1, 6);

    exp_req(0, 32'h400, 32'h0, 4'b0000);
    exp_done(32'h000000AB, 0);
    run(1, 0, 3'b100, 32'h401, 0, 32'h0000AB00, 0, 3, 6);

    exp_req(0, 32'h500, 32'h0, 4'b0000);
    exp_done(32'h55AA55AA, 0);
    run(1, 0, 3'b010, 32'h500, 0, 32'h55AA55AA, 0, 2, 5);

    ready_dly = 50; rvalid_dly = -1;
    exp_req(0, 32'h600, 32'h0, 4'b0000);
    mem_readM = 1; mem_sizeM = 3'b010; addrM = 32'h600;
    n = 0;
    while (!dbus_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("valid_before_rst", 32'(dbus_valid), 1);
    #2;
    mem_readM = 0;
    rst = 1;
    #1;
    chk("rst_mid_valid", 32'(dbus_valid), 0);
    chk("rst_mid_read_data", read_dataM, 0);
    chk("rst_mid_addr", dbus_addr, 0);
    chk("rst_mid_stall", 32'(stallM), 0);
    q_req.delete();
    q_done.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    exp_req(0, 32'h104, 32'h0, 4'b0000);
    exp_done(32'h0000BEEF, 0);
    run(1, 0, 3'b101, 32'h106, 0, 32'hBEEF0000, 0, 0, 3);

    repeat (3) @(posedge clk);
    chk("req_queue_empty", 32'(q_req.size()), 0);
    chk("done_queue_empty", 32'(q_done.size()), 0);
    chk("misalign_all_seen", 32'(q_mis), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-stage load/store unit for the pipelined RISC-V core.
- Consumes the decoded memory controls (read/write, size/signedness in funct3 encoding) and drives a single-outstanding data bus with valid/ready request and response handshakes.
- Performs byte-lane steering on stores and lane extraction with sign/zero extension on loads.
- Stalls the pipeline while an access is in flight.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles waiting for a response before a bus error; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- mem_readM  in  1  MEM-stage load
- mem_writeM  in  1  MEM-stage store
- mem_sizeM  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addrM  in  ADDR_W  byte address (ALU result)
- write_dataM  in  32  store data, right-aligned
- read_dataM  out  32  extended load result
- stallM  out  1  freeze IF..MEM
- misalignM  out  1  misaligned or illegal-encoding access, one-cycle pulse
- bus_errM  out  1  watchdog timeout, one-cycle pulse
- dbus_valid  out  1  request valid
- dbus_ready  in  1  request accepted
- dbus_we  out  1  write request
- dbus_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- dbus_wdata  out  32  lane-replicated store data
- dbus_wstrb  out  4  byte enables
- dbus_rvalid  in  1  response (read data or write ack)
- dbus_rdata  in  32  read word

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- On reset: state IDLE, read_dataM=0, dbus_valid=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_wstrb=0, misalignM=0, bus_errM=0, timeout counter=0.
- Mid-operation reset aborts the access and drops dbus_valid immediately.
- Access present = mem_readM|mem_writeM.
- Illegal cases, all raising misalignM:
  - both mem_readM and mem_writeM set;
  - mem_sizeM in {011,110,111};
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0.
- FSM states IDLE, REQ, RESP, DONE:
  - IDLE: on a legal access, latch the request into registers and go to REQ. On an illegal access, pulse misalignM for one cycle, stay in IDLE, issue no bus request, keep stallM=0.
  - REQ: dbus_valid=1 and the request fields held stable until dbus_ready; on the handshake go to RESP.
  - RESP: wait for dbus_rvalid. dbus_rvalid outside RESP is ignored. On dbus_rvalid, capture the extracted load data (reads only) and go to DONE.
  - DONE: one cycle; stallM=0 so the pipeline advances; return to IDLE unconditionally. The access still presented during DONE is not re-issued.
- stallM = (IDLE & legal access) | REQ | RESP. stallM is combinational from the inputs in IDLE.
- Minimum latency with dbus_ready and dbus_rvalid each asserted on the first eligible cycle: IDLE→REQ→RESP→DONE, i.e. 3 stall cycles and the result visible in cycle 4.
- Store lanes, with o=addr[1:0]:
  - B: wdata={4{d[7:0]}}, wstrb=0001<<o.
  - H: wdata={2{d[15:0]}}, wstrb=0011<<o.
  - W: wdata=d, wstrb=1111.
- Reads drive wstrb=0000 and wdata=0.
- Load extraction: s=rdata>>(8*o); B sign-extends s[7:0]; BU zero-extends s[7:0]; H/HU likewise on s[15:0]; W passes through.
- read_dataM holds its value until the next read completes; writes do not modify it.
- Watchdog, when TIMEOUT≠0:
  - The counter clears on entry to RESP and increments each cycle in RESP.
  - When the counter reaches TIMEOUT without dbus_rvalid: pulse bus_errM, set read_dataM=0, go to DONE.
  - dbus_rvalid in the same cycle as the timeout wins; no error is raised.

Decomposition:
- Shared package (core_pkg): mem_size constants MEM_B/H/W/BU/HU; lsu_state_t enum {IDLE,REQ,RESP,DONE}.
- One combinational sub-module, lsu_align: store lane steering and wstrb generation, plus load extraction and extension.
- lsu keeps the FSM, the request registers and the watchdog.

Test Plan:
- SW addr=0x100 d=0xDEADBEEF, ready and rvalid immediate → dbus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stallM high for exactly 3 cycles.
- SB addr=0x103 d=0x000000A5 → wdata=0xA5A5A5A5, wstrb=1000, dbus_addr=0x100.
- LB addr=0x102 with rdata=0x12F03456 → read_dataM=0xFFFFFFF0. LBU at the same address → 0x000000F0. LHU addr=0x102 → 0x000012F0.
- LW addr=0x101 → misalignM pulses, no dbus_valid, stallM=0. Read and write asserted together → misalignM pulses.
- dbus_ready held low 5 cycles → dbus_valid and the request fields stable throughout, stallM high throughout; completes after ready rises.
- TIMEOUT=4, no dbus_rvalid → bus_errM pulses after 4 RESP cycles, read_dataM=0, FSM returns to IDLE. Assert rst mid-REQ → dbus_valid=0 immediately.
